// File: rtl/pipe_sched_if.sv
// Operand/result handshake bundle for pipe_sched.
// slave = scheduler side, master = requesters plus shared datapath.
interface pipe_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [23:0] req0_ops;
  logic        req1_valid;
  logic        req1_ready;
  logic [23:0] req1_ops;
  logic [23:0] dp_ops;
  logic [3:0]  dp_out;
  logic        res0_valid;
  logic        res0_ready;
  logic [3:0]  res0_data;
  logic        res1_valid;
  logic        res1_ready;
  logic [3:0]  res1_data;
  logic        busy;

  modport slave (
    input  req0_valid, req0_ops, req1_valid, req1_ops, dp_out, res0_ready, res1_ready,
    output req0_ready, req1_ready, dp_ops, res0_valid, res0_data, res1_valid, res1_data, busy
  );

  modport master (
    output req0_valid, req0_ops, req1_valid, req1_ops, dp_out, res0_ready, res1_ready,
    input  req0_ready, req1_ready, dp_ops, res0_valid, res0_data, res1_valid, res1_data, busy
  );
endinterface

// File: rtl/pipe_sched.sv
// Two-requester credit-based scheduler for a shared fixed-latency datapath with
// per-requester in-order result FIFOs; grants alternate on ties.
module pipe_sched #(
  parameter int LAT    = 3,
  parameter int FDEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  pipe_sched_if.slave bus
);
  localparam int AW = $clog2(FDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] FULL = (CW + 1)'(FDEPTH);

  logic [1:0]    req_vld, res_rdy, elig, grant, push, pop;
  logic [CW-1:0] inflight_q [2];
  logic [CW-1:0] inflight_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [AW-1:0] wptr_q [2];
  logic [AW-1:0] rptr_q [2];
  logic [3:0]    mem_q [2][FDEPTH];
  logic          last_q;
  logic [23:0]   dp_ops_q, dp_ops_d;
  logic [LAT-1:0] tag_vld_q, tag_id_q;

  assign req_vld = {bus.req1_valid, bus.req0_valid};
  assign res_rdy = {bus.res1_ready, bus.res0_ready};

  always_comb begin
    elig     = '0;
    grant    = '0;
    push     = '0;
    pop      = '0;
    dp_ops_d = '0;
    for (int i = 0; i < 2; i++) begin
      // Occupancy counts results still in the pipe so a push always finds room.
      elig[i] = req_vld[i] && (({1'b0, cnt_q[i]} + {1'b0, inflight_q[i]}) < FULL);
      push[i] = tag_vld_q[LAT-1] && (tag_id_q[LAT-1] == 1'(i));
      pop[i]  = (cnt_q[i] != '0) && res_rdy[i];
    end
    if (!rst) begin
      if (&elig) grant = last_q ? 2'b01 : 2'b10;
      else       grant = elig;
    end
    for (int i = 0; i < 2; i++) begin
      inflight_d[i] = inflight_q[i] + CW'(grant[i]) - CW'(push[i]);
      cnt_d[i]      = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
    if (grant[0])      dp_ops_d = bus.req0_ops;
    else if (grant[1]) dp_ops_d = bus.req1_ops;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_ops_q  <= '0;
      last_q    <= 1'b1;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        inflight_q[i] <= '0;
        cnt_q[i]      <= '0;
        wptr_q[i]     <= '0;
        rptr_q[i]     <= '0;
      end
    end else begin
      dp_ops_q <= dp_ops_d;
      if (|grant) last_q <= grant[1];
      // Tag line never stalls: it tracks the datapath's fixed latency exactly.
      tag_vld_q[0] <= |grant;
      tag_id_q[0]  <= grant[1];
      for (int k = 1; k < LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
      for (int i = 0; i < 2; i++) begin
        inflight_q[i] <= inflight_d[i];
        cnt_q[i]      <= cnt_d[i];
        if (push[i]) wptr_q[i] <= wptr_q[i] + AW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i] && !rst) mem_q[i][wptr_q[i]] <= bus.dp_out;
    end
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.dp_ops     = dp_ops_q;
  assign bus.res0_valid = !rst && (cnt_q[0] != '0);
  assign bus.res1_valid = !rst && (cnt_q[1] != '0);
  assign bus.res0_data  = mem_q[0][rptr_q[0]];
  assign bus.res1_data  = mem_q[1][rptr_q[1]];
  assign bus.busy       = !rst && ((inflight_q[0] | inflight_q[1] | cnt_q[0] | cnt_q[1]) != '0);
endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched: arbitration/credit vector table plus corner sequences,
// with an XOR datapath model and per-requester result scoreboards.
module tb_pipe_sched;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   pops0;
  int   pops1;

  pipe_sched_if bus();

  pipe_sched #(.LAT(3), .FDEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] xr(input logic [23:0] o);
    return o[23:20] ^ o[19:16] ^ o[15:12] ^ o[11:8] ^ o[7:4] ^ o[3:0];
  endfunction

  // Datapath model: dp_ops register plus two more stages gives three edges of latency.
  logic [3:0] dp_s1, dp_s2;
  always @(posedge clk) begin
    dp_s1 <= xr(bus.dp_ops);
    dp_s2 <= dp_s1;
  end
  assign bus.dp_out = dp_s2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] q0[$];
  logic [3:0] q1[$];

  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (bus.res0_valid && bus.res0_ready) begin
        if (q0.size() == 0) chk("res0_unexpected", 32'(bus.res0_data), 32'hFFFF_FFFF);
        else chk("res0_order", 32'(bus.res0_data), 32'(q0.pop_front()));
        pops0++;
      end
      if (bus.res1_valid && bus.res1_ready) begin
        if (q1.size() == 0) chk("res1_unexpected", 32'(bus.res1_data), 32'hFFFF_FFFF);
        else chk("res1_order", 32'(bus.res1_data), 32'(q1.pop_front()));
        pops1++;
      end
      if (bus.req0_valid && bus.req0_ready) q0.push_back(xr(bus.req0_ops));
      if (bus.req1_valid && bus.req1_ready) q1.push_back(xr(bus.req1_ops));
    end
  end

  typedef struct {
    logic rst, v0, v1, r0, r1, e0, e1;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic a, input logic b, input logic c,
                              input logic d, input logic e, input logic f);
    vec_t t;
    t.rst = r; t.v0 = a; t.v1 = b; t.r0 = c; t.r1 = d; t.e0 = e; t.e1 = f;
    return t;
  endfunction

  vec_t        tbl[$];
  logic [23:0] o0, o1, exp_dp;
  logic [23:0] s3 [5];
  int          k;
  int          base;
  logic        acc;

  initial begin
    checks = 0; errors = 0; pops0 = 0; pops1 = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_ops = '0; bus.req1_ops = '0;
    bus.res0_ready = 1'b0; bus.res1_ready = 1'b0;

    // Arbitration from reset: ties alternate starting with requester 0.
    tbl.push_back(mk(1,1,1,1,1,0,0));
    tbl.push_back(mk(1,1,1,1,1,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,0));
    tbl.push_back(mk(0,1,1,1,1,1,0));
    tbl.push_back(mk(0,1,1,1,1,0,1));
    tbl.push_back(mk(0,1,1,1,1,1,0));
    tbl.push_back(mk(0,0,1,1,1,0,1));
    tbl.push_back(mk(0,0,0,1,1,0,0));
    tbl.push_back(mk(0,1,1,1,1,1,0));
    tbl.push_back(mk(0,1,0,1,1,1,0));
    tbl.push_back(mk(0,1,1,1,1,0,1));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,1,1,0,0));
    // Backpressure on requester 0 (res0_ready=0); requester 1 limited only by its own credit.
    tbl.push_back(mk(1,1,1,0,1,0,0));
    tbl.push_back(mk(0,1,1,0,1,1,0));
    tbl.push_back(mk(0,1,1,0,1,0,1));
    tbl.push_back(mk(0,1,1,0,1,1,0));
    tbl.push_back(mk(0,1,1,0,1,0,1));
    tbl.push_back(mk(0,1,1,0,1,1,0));
    tbl.push_back(mk(0,1,1,0,1,0,1));
    tbl.push_back(mk(0,1,1,0,1,1,0));
    tbl.push_back(mk(0,1,1,0,1,0,1));
    tbl.push_back(mk(0,1,1,0,1,0,1));
    tbl.push_back(mk(0,1,1,0,1,0,1));
    tbl.push_back(mk(0,1,1,0,1,0,1));
    tbl.push_back(mk(0,1,1,0,1,0,0));
    tbl.push_back(mk(0,1,1,0,1,0,1));
    tbl.push_back(mk(0,1,1,0,1,0,1));
    tbl.push_back(mk(0,1,1,0,1,0,1));
    tbl.push_back(mk(0,1,1,0,1,0,1));
    tbl.push_back(mk(0,1,1,1,1,0,0));
    tbl.push_back(mk(0,1,1,0,1,1,0));
    tbl.push_back(mk(0,1,1,0,1,0,1));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0,0,0,1,1,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      o0 = 24'(i * 32'h0001357 + 32'h0A0000);
      o1 = 24'(i * 32'h0000F17 + 32'h50000F);
      rst = tbl[i].rst;
      bus.req0_valid = tbl[i].v0; bus.req1_valid = tbl[i].v1;
      bus.req0_ops = o0; bus.req1_ops = o1;
      bus.res0_ready = tbl[i].r0; bus.res1_ready = tbl[i].r1;
      #1;
      chk($sformatf("rdy0[%0d]", i), 32'(bus.req0_ready), 32'(tbl[i].e0));
      chk($sformatf("rdy1[%0d]", i), 32'(bus.req1_ready), 32'(tbl[i].e1));
      if (tbl[i].rst) begin
        chk($sformatf("rst_busy[%0d]", i), 32'(bus.busy), 32'd0);
        chk($sformatf("rst_res0v[%0d]", i), 32'(bus.res0_valid), 32'd0);
      end
      exp_dp = tbl[i].e0 ? o0 : (tbl[i].e1 ? o1 : 24'h0);
      step();
      chk($sformatf("dp_ops[%0d]", i), 32'(bus.dp_ops), 32'(exp_dp));
    end
    rst = 1'b0;

    // Single issue: latency, result value and busy window.
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b0; bus.res0_ready = 1'b0;
    bus.req0_ops = 24'h01A82D;
    #1;
    chk("single_rdy", 32'(bus.req0_ready), 32'd1);
    step();
    bus.req0_valid = 1'b0;
    chk("single_dp", 32'(bus.dp_ops), 32'h01A82D);
    chk("single_busy0", 32'(bus.busy), 32'd1);
    step();
    chk("single_v1", 32'(bus.res0_valid), 32'd0);
    chk("single_busy1", 32'(bus.busy), 32'd1);
    step();
    chk("single_v2", 32'(bus.res0_valid), 32'd0);
    step();
    chk("single_v3", 32'(bus.res0_valid), 32'd1);
    chk("single_data", 32'(bus.res0_data), 32'hC);
    chk("single_busy3", 32'(bus.busy), 32'd1);
    bus.res0_ready = 1'b1;
    step();
    chk("single_popped", 32'(bus.res0_valid), 32'd0);
    chk("single_idle", 32'(bus.busy), 32'd0);

    // Ten back-to-back requester 0 sets: pointers wrap, order kept.
    base = pops0; k = 0;
    for (int c = 0; c < 80 && k < 10; c++) begin
      bus.req0_valid = 1'b1;
      bus.req0_ops = 24'((k + 1) * 32'h0031A7 + 32'h900000);
      #1;
      acc = bus.req0_ready;
      step();
      if (acc) k++;
    end
    bus.req0_valid = 1'b0;
    chk("wrap_issued", 32'(k), 32'd10);
    for (int c = 0; c < 40 && pops0 < base + 10; c++) step();
    chk("wrap_pops", 32'(pops0 - base), 32'd10);
    chk("wrap_empty", 32'(bus.res0_valid), 32'd0);

    // Max occupancy: pop and push on the same edge, credit returns a cycle later.
    bus.res0_ready = 1'b0;
    s3[0] = 24'h123456; s3[1] = 24'hFEDCBA; s3[2] = 24'h0F0F33;
    s3[3] = 24'hA5A5A5; s3[4] = 24'h777001;
    base = pops0; k = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      bus.req0_valid = 1'b1;
      bus.req0_ops = s3[k];
      #1;
      acc = bus.req0_ready;
      step();
      if (acc) k++;
    end
    bus.req0_valid = 1'b0;
    chk("full_fill3", 32'(k), 32'd3);
    for (int c = 0; c < 5; c++) step();
    bus.req0_valid = 1'b1; bus.req0_ops = s3[3];
    #1;
    chk("full_issue4", 32'(bus.req0_ready), 32'd1);
    step();
    bus.req0_valid = 1'b0;
    step();
    step();
    bus.req0_valid = 1'b1; bus.req0_ops = s3[4]; bus.res0_ready = 1'b1;
    #1;
    chk("credit_zero", 32'(bus.req0_ready), 32'd0);
    chk("full_head", 32'(bus.res0_data), 32'(xr(s3[0])));
    step();
    bus.res0_ready = 1'b0;
    #1;
    chk("pushpop_valid", 32'(bus.res0_valid), 32'd1);
    chk("pushpop_head", 32'(bus.res0_data), 32'(xr(s3[1])));
    chk("credit_back", 32'(bus.req0_ready), 32'd1);
    step();
    bus.req0_valid = 1'b0; bus.res0_ready = 1'b1;
    for (int c = 0; c < 30 && pops0 < base + 5; c++) step();
    chk("full_pops", 32'(pops0 - base), 32'd5);

    // Reset one edge after issue: the in-flight result must vanish.
    bus.req0_valid = 1'b1; bus.req0_ops = 24'h01A82D;
    #1;
    chk("rstmid_rdy", 32'(bus.req0_ready), 32'd1);
    step();
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("rstmid_v[%0d]", c), 32'(bus.res0_valid), 32'd0);
      chk($sformatf("rstmid_busy[%0d]", c), 32'(bus.busy), 32'd0);
      step();
    end
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    chk("rstmid_first0", 32'(bus.req0_ready), 32'd1);
    chk("rstmid_first1", 32'(bus.req1_ready), 32'd0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    #1;

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
